// File: rtl/str_arb_pkg.sv
// Shared types and helpers for the packet round-robin arbiter.
//   arb_state_e : arbiter FSM states (IDLE, LOCKED)
//   idx_w(n)    : index width for n requesters, clog2(n) with a floor of 1
package str_arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/str_rr_picker.sv
// Combinational masked priority picker.
// Finds the first set bit of req scanning upward from rr_ptr, wrapping
// modulo NUM_REQ.
//   req    : request vector
//   rr_ptr : scan start index (must be < NUM_REQ)
//   found  : any request set
//   idx    : winning index (0 when none found)
module str_rr_picker
  import str_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IW      = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      rr_ptr,
  output logic               found,
  output logic [IW-1:0]      idx
);

  logic [IW-1:0] pos;

  // Walk NUM_REQ positions starting at rr_ptr; the first hit wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    pos   = rr_ptr;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && req[pos]) begin
        found = 1'b1;
        idx   = pos;
      end
      pos = (pos == IW'(NUM_REQ - 1)) ? '0 : pos + IW'(1);
    end
  end

endmodule

// File: rtl/str_rr_arbiter.sv
// Packet round-robin arbiter: shares one valid/ready output channel among
// NUM_REQ producers. A grant is taken in IDLE, held for a whole packet in
// LOCKED (zero-cycle pass-through), and released on the accepted last beat,
// which advances the round-robin pointer past the granted requester.
// Optional macro STR_ARB_TIMEOUT_EN adds a stall timeout that forcibly
// releases the grant after TIMEOUT_CYCLES cycles without an accepted beat.
//   clk, rst_n          : clock, async active-low reset
//   req_valid/data/last : per-requester beat in
//   req_ready           : per-requester beat accepted
//   out_valid/data/last : shared channel out, out_ready from the consumer
//   grant_idx           : current or most recent grant
//   busy                : grant held (LOCKED)
//   timeout_pulse       : one-cycle stall-timeout strobe (macro only)
module str_rr_arbiter
  import str_arb_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int DATA_W         = 8,
  parameter int TIMEOUT_CYCLES = 16,
  localparam int IW            = idx_w(NUM_REQ)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ-1:0][DATA_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]             req_last,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic                           out_valid,
  output logic [DATA_W-1:0]              out_data,
  output logic                           out_last,
  input  logic                           out_ready,
  output logic [IW-1:0]                  grant_idx,
  output logic                           busy
`ifdef STR_ARB_TIMEOUT_EN
  ,
  output logic                           timeout_pulse
`endif
);

  if (NUM_REQ < 1 || NUM_REQ > 16 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("str_rr_arbiter: NUM_REQ must be 1..16 and TIMEOUT_CYCLES >= 1");
  end

  arb_state_e    state, state_nxt;
  logic [IW-1:0] rr_ptr, ptr_nxt, grant_nxt, pick_idx, ptr_after;
  logic          found, locked, beat, expire;

  str_rr_picker #(.NUM_REQ(NUM_REQ), .IW(IW)) u_picker (
    .req    (req_valid),
    .rr_ptr (rr_ptr),
    .found  (found),
    .idx    (pick_idx)
  );

  assign locked    = (state == LOCKED);
  assign busy      = locked;
  assign out_valid = locked & req_valid[grant_idx];
  assign out_last  = locked & req_last[grant_idx];
  assign out_data  = locked ? req_data[grant_idx] : '0;
  assign beat      = out_valid & out_ready;
  assign ptr_after = (grant_idx == IW'(NUM_REQ - 1)) ? '0 : grant_idx + IW'(1);

  // Ready is offered to the grantee whether or not it is currently valid.
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_ready
    assign req_ready[i] = locked && (grant_idx == IW'(i)) && out_ready;
  end

`ifdef STR_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] stall_cnt;

  // Fires on the TIMEOUT_CYCLES-th consecutive LOCKED cycle without an
  // accepted beat, so the grant spans exactly TIMEOUT_CYCLES cycles; the
  // registered strobe then appears in the following IDLE cycle.
  assign expire = locked && !beat && (stall_cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt     <= '0;
      timeout_pulse <= 1'b0;
    end else begin
      timeout_pulse <= expire;
      if (!locked || beat) stall_cnt <= '0;
      else                 stall_cnt <= stall_cnt + CW'(1);
    end
  end
`else
  assign expire = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    ptr_nxt   = rr_ptr;
    grant_nxt = grant_idx;
    unique case (state)
      IDLE: begin
        if (found) begin
          state_nxt = LOCKED;
          grant_nxt = pick_idx;
        end
      end
      LOCKED: begin
        if ((beat && out_last) || expire) begin
          state_nxt = IDLE;
          ptr_nxt   = ptr_after;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      grant_idx <= '0;
    end else begin
      state     <= state_nxt;
      rr_ptr    <= ptr_nxt;
      grant_idx <= grant_nxt;
    end
  end

endmodule

// File: tb/tb_str_rr_arbiter.sv
// Self-checking bench for str_rr_arbiter: vector table, directed
// multi-cycle sequences, a NUM_REQ=1 instance and a randomized run against
// a packet-level reference model.
module tb_str_rr_arbiter;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [3:0]      rv, rl, rr;
  logic [3:0][7:0] rd;
  logic            ov, ol, ordy, bsy;
  logic [7:0]      od;
  logic [1:0]      gnt;
  logic            s_rv, s_rl, s_rr, s_ov, s_ol, s_ordy, s_bsy;
  logic [7:0]      s_rd, s_od;
  logic [0:0]      s_gnt;
`ifdef STR_ARB_TIMEOUT_EN
  logic            tp, s_tp;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  str_rr_arbiter #(.NUM_REQ(4), .DATA_W(8), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(rv), .req_data(rd), .req_last(rl),
    .req_ready(rr), .out_valid(ov), .out_data(od), .out_last(ol),
    .out_ready(ordy), .grant_idx(gnt), .busy(bsy)
`ifdef STR_ARB_TIMEOUT_EN
    , .timeout_pulse(tp)
`endif
  );

  str_rr_arbiter #(.NUM_REQ(1), .DATA_W(8), .TIMEOUT_CYCLES(16)) dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(s_rv), .req_data(s_rd), .req_last(s_rl),
    .req_ready(s_rr), .out_valid(s_ov), .out_data(s_od), .out_last(s_ol),
    .out_ready(s_ordy), .grant_idx(s_gnt), .busy(s_bsy)
`ifdef STR_ARB_TIMEOUT_EN
    , .timeout_pulse(s_tp)
`endif
  );

  typedef struct {
    logic [3:0] rv, rl;
    logic       ordy;
    logic       busy;
    logic [1:0] gnt;
    logic       ov;
    logic [3:0] rr;
    logic [7:0] data;
    logic       last;
  } vec_t;

  vec_t tbl[19];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    rv = '0; rl = '0; ordy = 1'b0;
    s_rv = 1'b0; s_rl = 1'b0; s_ordy = 1'b0; s_rd = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Packet-level reference model state for the random run.
  bit         m_busy;
  int         m_gnt, m_ptr;
  bit         pact[4];
  int         plen[4], pbeat[4];
  logic [7:0] pd[4];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    // {rv, rl, ordy, busy, gnt, out_valid, req_ready, out_data, out_last}
    tbl[0]  = '{4'b1111, 4'b1111, 1, 0, 0, 0, 4'b0000, 8'h00, 0};
    tbl[1]  = '{4'b1111, 4'b1111, 1, 1, 0, 1, 4'b0001, 8'hA0, 1};
    tbl[2]  = '{4'b1111, 4'b1111, 1, 0, 0, 0, 4'b0000, 8'h00, 0};
    tbl[3]  = '{4'b1111, 4'b1111, 1, 1, 1, 1, 4'b0010, 8'hA1, 1};
    tbl[4]  = '{4'b1111, 4'b1111, 1, 0, 1, 0, 4'b0000, 8'h00, 0};
    tbl[5]  = '{4'b1111, 4'b1111, 1, 1, 2, 1, 4'b0100, 8'hA2, 1};
    tbl[6]  = '{4'b0001, 4'b1111, 1, 0, 2, 0, 4'b0000, 8'h00, 0};
    tbl[7]  = '{4'b0001, 4'b1111, 1, 1, 0, 1, 4'b0001, 8'hA0, 1};
    tbl[8]  = '{4'b0011, 4'b1111, 1, 0, 0, 0, 4'b0000, 8'h00, 0};
    tbl[9]  = '{4'b0011, 4'b1111, 1, 1, 1, 1, 4'b0010, 8'hA1, 1};
    tbl[10] = '{4'b0000, 4'b0000, 1, 0, 1, 0, 4'b0000, 8'h00, 0};
    tbl[11] = '{4'b0100, 4'b0000, 0, 0, 1, 0, 4'b0000, 8'h00, 0};
    tbl[12] = '{4'b0000, 4'b0000, 1, 1, 2, 0, 4'b0100, 8'hA2, 0};
    tbl[13] = '{4'b0101, 4'b0000, 0, 1, 2, 1, 4'b0000, 8'hA2, 0};
    tbl[14] = '{4'b0101, 4'b0100, 1, 1, 2, 1, 4'b0100, 8'hA2, 1};
    tbl[15] = '{4'b0001, 4'b0000, 1, 0, 2, 0, 4'b0000, 8'h00, 0};
    tbl[16] = '{4'b0001, 4'b0000, 1, 1, 0, 1, 4'b0001, 8'hA0, 0};
    tbl[17] = '{4'b0001, 4'b0001, 1, 1, 0, 1, 4'b0001, 8'hA0, 1};
    tbl[18] = '{4'b0000, 4'b0000, 1, 0, 0, 0, 4'b0000, 8'h00, 0};

    // ---- reset state ----
    rd = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    do_reset();
    #1;
    chk("rst_busy", bsy, 0);
    chk("rst_grant", gnt, 0);
    chk("rst_out_valid", ov, 0);
    chk("rst_out_data", od, 0);
    chk("rst_out_last", ol, 0);
    chk("rst_req_ready", rr, 0);

    // ---- vector table: fairness, wrap, withdrawal, stall, multi-beat ----
    for (int i = 0; i < 19; i++) begin
      rv = tbl[i].rv; rl = tbl[i].rl; ordy = tbl[i].ordy;
      #1;
      chk($sformatf("tbl%0d_busy", i), bsy, tbl[i].busy);
      chk($sformatf("tbl%0d_grant", i), gnt, tbl[i].gnt);
      chk($sformatf("tbl%0d_valid", i), ov, tbl[i].ov);
      chk($sformatf("tbl%0d_ready", i), rr, tbl[i].rr);
      chk($sformatf("tbl%0d_data", i), od, tbl[i].data);
      chk($sformatf("tbl%0d_last", i), ol, tbl[i].last);
      step();
    end

    // ---- packet hold with backpressure (req 2 vs req 0) ----
    do_reset();
    rv = 4'b0010; rl = 4'b0010; ordy = 1'b1;
    step(); step();                         // grant 1 single beat, ptr -> 2
    rv = 4'b0101; rl = 4'b0000; rd[2] = 8'h11; rd[0] = 8'hB0;
    step();                                 // IDLE picks 2
    ordy = 1'b0; #1;
    chk("bp_stall_data", od, 8'h11); chk("bp_stall_busy", bsy, 1);
    chk("bp_stall_ready", rr, 4'b0000);
    step();
    ordy = 1'b1; #1;
    chk("bp_a1_data", od, 8'h11); chk("bp_a1_ready", rr, 4'b0100);
    step();
    rd[2] = 8'h12; #1;
    chk("bp_a2_data", od, 8'h12); chk("bp_a2_busy", bsy, 1);
    step();
    rd[2] = 8'h13; rl[2] = 1'b1; #1;
    chk("bp_a3_data", od, 8'h13); chk("bp_a3_last", ol, 1);
    step();
    rv = 4'b0001; rl = 4'b0000; #1;
    chk("bp_after_busy", bsy, 0);
    step(); #1;
    chk("bp_next_grant", gnt, 0); chk("bp_next_busy", bsy, 1);

    // ---- reset mid-packet ----
    rd = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    do_reset();
    rv = 4'b0100; rl = 4'b0100; ordy = 1'b1;
    step(); step();                         // single beat from 2, ptr -> 3
    rl = 4'b0000;
    step(); step();                         // grant 2, beat 1 accepted
    #1;
    chk("mid_beat2_valid", ov, 1);
    rst_n = 1'b0; #1;
    chk("mid_rst_valid", ov, 0); chk("mid_rst_busy", bsy, 0);
    chk("mid_rst_grant", gnt, 0); chk("mid_rst_ready", rr, 0);
    chk("mid_rst_data", od, 0); chk("mid_rst_last", ol, 0);
    @(posedge clk); #1;
    rst_n = 1'b1; rv = 4'b1100; #1;
    chk("mid_rel_busy", bsy, 0);
    step(); #1;
    chk("mid_ptr0_grant", gnt, 2);          // scan from 0 reaches 2 before 3

    // ---- NUM_REQ = 1: back-to-back 2-beat packets ----
    do_reset();
    s_rv = 1'b1; s_ordy = 1'b1; s_rd = 8'h5A;
    for (int p = 0; p < 2; p++) begin
      s_rl = 1'b0; #1;
      chk($sformatf("n1_p%0d_idle", p), s_bsy, 0);
      step();
      #1;
      chk($sformatf("n1_p%0d_b0_busy", p), s_bsy, 1);
      chk($sformatf("n1_p%0d_b0_grant", p), s_gnt, 0);
      chk($sformatf("n1_p%0d_b0_data", p), s_od, 8'h5A);
      step();
      s_rl = 1'b1; #1;
      chk($sformatf("n1_p%0d_b1_last", p), s_ol, 1);
      chk($sformatf("n1_p%0d_b1_ready", p), s_rr, 1);
      step();
    end
    s_rv = 1'b0; #1;
    chk("n1_end_busy", s_bsy, 0);

    // ---- randomized run against the packet-level model ----
    do_reset();
    m_busy = 0; m_gnt = 0; m_ptr = 0;
    for (int i = 0; i < 4; i++) pact[i] = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      logic [3:0] e_rr;
      logic [7:0] e_d;
      logic       e_v, e_l;
      for (int i = 0; i < 4; i++) begin
        if (!pact[i] && $urandom_range(0, 3) == 0) begin
          pact[i] = 1; plen[i] = $urandom_range(1, 3); pbeat[i] = 0;
          pd[i] = 8'($urandom);
        end
        rv[i] = pact[i];
        rl[i] = pact[i] && (pbeat[i] == plen[i] - 1);
        rd[i] = pact[i] ? pd[i] : 8'($urandom);
      end
      ordy = ($urandom_range(0, 3) != 0);
      #1;
      e_v  = m_busy && rv[m_gnt];
      e_l  = m_busy && rl[m_gnt];
      e_d  = m_busy ? rd[m_gnt] : 8'h00;
      e_rr = m_busy ? (4'(ordy) << m_gnt) : 4'b0000;
      chk("rnd_busy", bsy, m_busy);
      chk("rnd_grant", gnt, m_gnt);
      chk("rnd_valid", ov, e_v);
      chk("rnd_data", od, e_d);
      chk("rnd_last", ol, e_l);
      chk("rnd_ready", rr, e_rr);
      if (!m_busy) begin
        for (int k = 0; k < 4; k++) begin
          if (!m_busy && rv[(m_ptr + k) % 4]) begin
            m_busy = 1; m_gnt = (m_ptr + k) % 4;
          end
        end
      end else if (e_v && ordy) begin
        pbeat[m_gnt]++;
        pd[m_gnt] = 8'($urandom);
        if (e_l) begin
          pact[m_gnt] = 0;
          m_busy = 0;
          m_ptr = (m_gnt + 1) % 4;
        end
      end
      step();
    end

`ifdef STR_ARB_TIMEOUT_EN
    // ---- stall timeout: 16 LOCKED cycles then a one-cycle strobe ----
    do_reset();
    rv = 4'b0110; rl = 4'b0000; ordy = 1'b0;
    step();
    for (int k = 0; k < 16; k++) begin
      #1;
      chk($sformatf("to_locked%0d_busy", k), bsy, 1);
      chk($sformatf("to_locked%0d_pulse", k), tp, 0);
      step();
    end
    #1;
    chk("to_idle_busy", bsy, 0); chk("to_pulse", tp, 1);
    step(); #1;
    chk("to_next_grant", gnt, 2); chk("to_pulse_clear", tp, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
